// File: rtl/comparador_pkg.sv
// Shared types and elaboration helpers for the serial MSB-first comparator.
package comparador_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} estado_t;

  function automatic int num_chunks(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int width, input int bpc);
    return (width >= 1) && (bpc >= 1) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/celda_iterativa_k.sv
// One comparator cell over a BITS_PER_CYCLE chunk: once a decision exists it is held,
// otherwise the chunk pair decides it.
module celda_iterativa_k #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] a,
  input  logic [BITS_PER_CYCLE-1:0] b,
  input  logic                      f_prev,
  input  logic                      g_prev,
  output logic                      f_next,
  output logic                      g_next
);

  always_comb begin
    f_next = f_prev;
    g_next = g_prev;
    if (!(f_prev | g_prev)) begin
      f_next = (a > b);
      g_next = (a < b);
    end
  end

endmodule

// File: rtl/comparador_serial_izq_der.sv
// Multi-cycle magnitude comparator: scans A and B from the MSB chunk down, publishing
// registered A>B / A<B / A==B with a one-cycle done pulse.
module comparador_serial_izq_der
  import comparador_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED         = 0,
  parameter int EARLY_EXIT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             f,
  output logic             g,
  output logic             eq
);

  localparam int N     = num_chunks(WIDTH, BITS_PER_CYCLE);
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  // Flipping the sign bit turns two's complement into offset binary, so the
  // unsigned chunk compare yields the signed order.
  localparam logic [WIDTH-1:0] MSB_MASK = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  if (!params_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
    $error("comparador_serial_izq_der: WIDTH must be >= 1 and a multiple of BITS_PER_CYCLE");
  end

  estado_t          state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IDX_W-1:0] idx;
  logic             fi, gi;
  logic             fi_c, gi_c;
  logic             fi_n, gi_n;

  celda_iterativa_k #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_celda (
    .a      (a_sh[WIDTH-1 -: BITS_PER_CYCLE]),
    .b      (b_sh[WIDTH-1 -: BITS_PER_CYCLE]),
    .f_prev (fi),
    .g_prev (gi),
    .f_next (fi_c),
    .g_next (gi_c)
  );

  always_comb begin
    state_n = state;
    fi_n    = fi;
    gi_n    = gi;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = COMPARE;
          fi_n    = 1'b0;
          gi_n    = 1'b0;
        end
      end
      COMPARE: begin
        fi_n = fi_c;
        gi_n = gi_c;
        if ((idx == LAST) || ((EARLY_EXIT != 0) && (fi_c | gi_c)))
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      idx   <= '0;
      fi    <= 1'b0;
      gi    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      f     <= 1'b0;
      g     <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_n;
      fi    <= fi_n;
      gi    <= gi_n;
      busy  <= (state_n == COMPARE);
      done  <= (state_n == DONE);
      if (state == IDLE && start) begin
        a_sh <= A ^ MSB_MASK;
        b_sh <= B ^ MSB_MASK;
        idx  <= '0;
      end else if (state == COMPARE) begin
        a_sh <= a_sh << BITS_PER_CYCLE;
        b_sh <= b_sh << BITS_PER_CYCLE;
        idx  <= idx + 1'b1;
      end
      if (state_n == DONE) begin
        f  <= fi_n;
        g  <= gi_n;
        eq <= ~(fi_n | gi_n);
      end
    end
  end

endmodule
